// File: rtl/vga_fb_pixel_pacer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_fb_pixel_pacer
// Purpose  : FIFO-buffered pacer that turns a bursty frame-buffer pixel stream
//            into one registered VGA pixel every CLK_DIV clocks.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_pixel_pacer #(
    parameter int COLOR_BITS     = 4,
    parameter int META_BITS      = 4,
    parameter int FIFO_ADDR_SIZE = 5,
    parameter int HEADROOM       = 8,
    parameter int PRIME_LEVEL    = 16,
    parameter int CLK_DIV        = 4,
    parameter bit SYNC_IDLE      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_hsync,
    input  logic                  in_vsync,
    input  logic [COLOR_BITS-1:0] in_red,
    input  logic [COLOR_BITS-1:0] in_grn,
    input  logic [COLOR_BITS-1:0] in_blu,
    input  logic [META_BITS-1:0]  in_meta,
    output logic                  in_enable,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic [COLOR_BITS-1:0] vga_red,
    output logic [COLOR_BITS-1:0] vga_grn,
    output logic [COLOR_BITS-1:0] vga_blu,
    output logic [META_BITS-1:0]  vga_meta,
    output logic                  pixel_tick,
    output logic                  running,
    output logic                  underflow,
    output logic                  overflow,
    input  logic                  err_clear
);

    localparam int c_DEPTH = 2 ** FIFO_ADDR_SIZE;
    localparam int c_WIDTH = 2 + 3 * COLOR_BITS + META_BITS;
    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [FIFO_ADDR_SIZE:0] c_DEPTH_CNT = (FIFO_ADDR_SIZE + 1)'(c_DEPTH);
    localparam logic [FIFO_ADDR_SIZE:0] c_EN_LIMIT  = (FIFO_ADDR_SIZE + 1)'(c_DEPTH - HEADROOM);
    localparam logic [FIFO_ADDR_SIZE:0] c_PRIME_CNT = (FIFO_ADDR_SIZE + 1)'(PRIME_LEVEL);
    localparam logic [c_DIV_W-1:0]      c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);

    typedef enum logic [0:0] {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                    r_state;
    logic [c_WIDTH-1:0]        r_mem [c_DEPTH];
    logic [FIFO_ADDR_SIZE-1:0] r_wr_ptr;
    logic [FIFO_ADDR_SIZE-1:0] r_rd_ptr;
    logic [FIFO_ADDR_SIZE:0]   r_count;
    logic [c_DIV_W-1:0]        r_div;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_tick;
    logic                      w_push;
    logic                      w_pop;
    logic [FIFO_ADDR_SIZE:0]   w_count_next;
    logic [c_WIDTH-1:0]        w_in_word;
    logic [c_WIDTH-1:0]        w_head;

    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign w_tick    = (r_state == ST_RUN) && (r_div == c_DIV_LAST);
    assign w_push    = in_valid && !w_full;
    assign w_pop     = w_tick && !w_empty;
    assign w_in_word = {in_hsync, in_vsync, in_red, in_grn, in_blu, in_meta};
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_PRIME;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_div      <= '0;
            in_enable  <= 1'b0;
            vga_hsync  <= SYNC_IDLE;
            vga_vsync  <= SYNC_IDLE;
            vga_red    <= '0;
            vga_grn    <= '0;
            vga_blu    <= '0;
            vga_meta   <= '0;
            pixel_tick <= 1'b0;
            running    <= 1'b0;
            underflow  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            in_enable  <= (w_count_next <= c_EN_LIMIT);
            pixel_tick <= w_tick;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            // Divider starts from zero on RUN entry so the first pixel lands
            // exactly CLK_DIV clocks after priming completes.
            if (r_state == ST_PRIME) begin
                if (w_count_next >= c_PRIME_CNT) begin
                    r_state <= ST_RUN;
                    running <= 1'b1;
                    r_div   <= '0;
                end
            end else begin
                r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
            end

            if (w_pop) begin
                {vga_hsync, vga_vsync, vga_red, vga_grn, vga_blu, vga_meta} <= w_head;
            end else if (w_tick) begin
                // Starved tick: blank the pixel but keep sync levels stable.
                vga_red  <= '0;
                vga_grn  <= '0;
                vga_blu  <= '0;
                vga_meta <= '0;
            end

            underflow <= err_clear ? 1'b0 : (underflow | (w_tick && w_empty));
            overflow  <= err_clear ? 1'b0 : (overflow | (in_valid && w_full));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_pixel_pacer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_pixel_pacer
// Purpose  : Two parameterisations of the pacer driven by shared stimulus and
//            compared every clock against a queue-level pixel model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_pixel_pacer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_hsync = 1'b0, in_vsync = 1'b0, err_clear = 1'b0;
    logic [3:0] in_red = '0, in_grn = '0, in_blu = '0, in_meta = '0;

    logic [1:0] en, hs, vs, pt, run, uf, ov;
    logic [1:0][3:0] red, grn, blu, meta;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vga_fb_pixel_pacer u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_hsync(in_hsync),
        .in_vsync(in_vsync), .in_red(in_red), .in_grn(in_grn), .in_blu(in_blu),
        .in_meta(in_meta), .in_enable(en[0]), .vga_hsync(hs[0]), .vga_vsync(vs[0]),
        .vga_red(red[0]), .vga_grn(grn[0]), .vga_blu(blu[0]), .vga_meta(meta[0]),
        .pixel_tick(pt[0]), .running(run[0]), .underflow(uf[0]), .overflow(ov[0]),
        .err_clear(err_clear)
    );

    vga_fb_pixel_pacer #(.PRIME_LEVEL(32), .CLK_DIV(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_hsync(in_hsync),
        .in_vsync(in_vsync), .in_red(in_red), .in_grn(in_grn), .in_blu(in_blu),
        .in_meta(in_meta), .in_enable(en[1]), .vga_hsync(hs[1]), .vga_vsync(vs[1]),
        .vga_red(red[1]), .vga_grn(grn[1]), .vga_blu(blu[1]), .vga_meta(meta[1]),
        .pixel_tick(pt[1]), .running(run[1]), .underflow(uf[1]), .overflow(ov[1]),
        .err_clear(err_clear)
    );

    // Reference model: pixel list plus a running flag and a clock-phase counter.
    logic [17:0] m_buf [2][32];
    int          m_head [2];
    int          m_cnt [2];
    int          m_div [2];
    bit          m_run [2];
    bit          m_tick [2];
    bit          m_en [2];
    bit          m_uf [2];
    bit          m_ov [2];
    logic [17:0] m_out [2];

    function automatic int prime_of(int k);
        return (k == 0) ? 16 : 32;
    endfunction

    function automatic int div_of(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(int k);
        m_head[k] = 0;
        m_cnt[k]  = 0;
        m_div[k]  = 0;
        m_run[k]  = 1'b0;
        m_tick[k] = 1'b0;
        m_en[k]   = 1'b0;
        m_uf[k]   = 1'b0;
        m_ov[k]   = 1'b0;
        m_out[k]  = {2'b11, 16'h0000};
    endtask

    task automatic model_step(int k);
        bit tick, uf_set, ov_set, push;
        if (!rst_n) begin
            model_reset(k);
            return;
        end
        tick   = m_run[k] && (m_div[k] == div_of(k) - 1);
        push   = in_valid && (m_cnt[k] < 32);
        ov_set = in_valid && (m_cnt[k] == 32);
        uf_set = tick && (m_cnt[k] == 0);
        if (tick) begin
            if (m_cnt[k] > 0) begin
                m_out[k]  = m_buf[k][m_head[k]];
                m_head[k] = (m_head[k] + 1) % 32;
                m_cnt[k]--;
            end else begin
                m_out[k][15:0] = 16'h0000;
            end
        end
        if (push) begin
            m_buf[k][(m_head[k] + m_cnt[k]) % 32] =
                {in_hsync, in_vsync, in_red, in_grn, in_blu, in_meta};
            m_cnt[k]++;
        end
        m_tick[k] = tick;
        m_en[k]   = (m_cnt[k] <= 24);
        if (!m_run[k]) begin
            if (m_cnt[k] >= prime_of(k)) begin
                m_run[k] = 1'b1;
                m_div[k] = 0;
            end
        end else begin
            m_div[k] = (m_div[k] + 1) % div_of(k);
        end
        m_uf[k] = err_clear ? 1'b0 : (m_uf[k] | uf_set);
        m_ov[k] = err_clear ? 1'b0 : (m_ov[k] | ov_set);
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("run%0d", k), 32'(run[k]), 32'(m_run[k]));
            check($sformatf("in_enable%0d", k), 32'(en[k]), 32'(m_en[k]));
            check($sformatf("pixel_tick%0d", k), 32'(pt[k]), 32'(m_tick[k]));
            check($sformatf("underflow%0d", k), 32'(uf[k]), 32'(m_uf[k]));
            check($sformatf("overflow%0d", k), 32'(ov[k]), 32'(m_ov[k]));
            check($sformatf("vga%0d", k),
                  32'({hs[k], vs[k], red[k], grn[k], blu[k], meta[k]}), 32'(m_out[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic drive(logic v, logic [17:0] w);
        in_valid = v;
        {in_hsync, in_vsync, in_red, in_grn, in_blu, in_meta} = w;
    endtask

    task automatic random_phase(int cycles, int pct);
        for (int i = 0; i < cycles; i++) begin
            drive(($urandom_range(0, 99) < pct), 18'($urandom));
            err_clear = ($urandom_range(0, 199) == 0);
            cycle();
        end
        err_clear = 1'b0;
    endtask

    initial begin
        model_reset(0);
        model_reset(1);

        // Reset held: inputs wiggle, outputs must stay idle.
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), 18'($urandom));
            err_clear = 1'($urandom);
            cycle();
        end
        check("reset_en", 32'(en[0]), 32'd0);
        check("reset_sync", 32'({hs[0], vs[0]}), 32'd3);
        drive(1'b0, 18'h0);
        err_clear = 1'b0;
        rst_n = 1'b1;

        // Prime with pixels 0x001.. back to back; continue to 33 for overflow on u_b.
        for (int i = 1; i <= 33; i++) begin
            drive(1'b1, {2'($urandom), 12'(i), 4'(i)});
            cycle();
            if (i == 16) begin
                check("A_running_at_16", 32'(run[0]), 32'd1);
                check("B_waits_for_32", 32'(run[1]), 32'd0);
            end
            if (i == 20) check("A_first_pixel", 32'({red[0], grn[0], blu[0]}), 32'h001);
            if (i == 24) check("A_second_pixel", 32'({red[0], grn[0], blu[0]}), 32'h002);
        end
        check("B_overflow", 32'(ov[1]), 32'd1);
        check("B_throttled", 32'(en[1]), 32'd0);

        drive(1'b0, 18'h0);
        err_clear = 1'b1;
        cycle();
        err_clear = 1'b0;
        check("B_overflow_cleared", 32'(ov[1]), 32'd0);

        // Starve both FIFOs.
        for (int i = 0; i < 200; i++) cycle();
        check("A_underflow", 32'(uf[0]), 32'd1);
        check("B_underflow", 32'(uf[1]), 32'd1);
        check("A_blank", 32'({red[0], grn[0], blu[0], meta[0]}), 32'd0);

        random_phase(1500, 30);

        // Asynchronous reset in the middle of RUN.
        rst_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        compare_all();
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 18'($urandom));
            cycle();
        end
        drive(1'b0, 18'h0);
        rst_n = 1'b1;

        random_phase(1500, 80);
        random_phase(500, 20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
